// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 outer-product matmul driver.
package matmul_pkg;

  localparam int DIM = 3;
  localparam int W   = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ACK,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Row-major flat index of element [i][j].
  function automatic int elem_idx(input int i, input int j);
    return DIM * i + j;
  endfunction

endpackage

// File: rtl/matmul3_outer_driver_if.sv
// Handshake and data bus between the matmul driver and one outer-product unit.
interface matmul3_outer_driver_if
  import matmul_pkg::*;
#(
  parameter int W = matmul_pkg::W
);

  logic           mm_ready;
  logic           mm_accept;
  logic           mm_valid;
  logic [3*W-1:0] mm_a;
  logic [3*W-1:0] mm_b;
  logic [9*W-1:0] mm_c;

  modport master (
    output mm_ready, mm_accept, mm_a, mm_b,
    input  mm_valid, mm_c
  );

  modport slave (
    input  mm_ready, mm_accept, mm_a, mm_b,
    output mm_valid, mm_c
  );

endinterface

// File: rtl/matmul3_acc_bank.sv
// Nine W-bit wrapping accumulators; clear has priority over add.
module matmul3_acc_bank
  import matmul_pkg::*;
#(
  parameter int W = matmul_pkg::W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clr,
  input  logic           i_add_en,
  input  logic [9*W-1:0] i_mm_c,
  output logic [9*W-1:0] o_acc
);

  logic [9*W-1:0] r_acc;

  for (genvar n = 0; n < DIM * DIM; n++) begin : g_acc
    always_ff @(posedge clk) begin
      if (rst || i_clr) begin
        r_acc[n*W +: W] <= '0;
      end else if (i_add_en) begin
        r_acc[n*W +: W] <= r_acc[n*W +: W] + i_mm_c[n*W +: W];
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/matmul3_outer_driver.sv
// 3x3 matmul as three outer-product passes through an external unit.
// Optional watchdog in WAIT enabled by MM_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for start
// REQ      | one-cycle request with column/row k
// WAIT     | waiting for mm_valid, accumulate on arrival
// ACK      | one-cycle result acknowledge
// DRAIN    | wait for mm_valid to fall
// DONE     | publish c_mat, pulse done
module matmul3_outer_driver
  import matmul_pkg::*;
#(
  parameter int W              = matmul_pkg::W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [9*W-1:0]                i_a_mat,
  input  logic [9*W-1:0]                i_b_mat,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic [9*W-1:0]                o_c_mat,
  matmul3_outer_driver_if.master        mm
);

  state_t         r_state;
  state_t         w_state_nx;
  logic [1:0]     r_k;
  logic [1:0]     w_k_nx;
  logic [9*W-1:0] r_a;
  logic [9*W-1:0] r_b;
  logic [9*W-1:0] r_c;
  logic [3*W-1:0] r_mm_a;
  logic [3*W-1:0] r_mm_b;
  logic           r_busy;
  logic           r_done;
  logic           r_ready;
  logic           r_accept;

  logic           w_clr;
  logic           w_add;
  logic           w_tmo_hit;
  logic           w_tmo_err;
  logic [9*W-1:0] w_a_src;
  logic [9*W-1:0] w_b_src;
  logic [3*W-1:0] w_mm_a;
  logic [3*W-1:0] w_mm_b;
  logic [9*W-1:0] w_acc;

`ifdef MM_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TMO_W-1:0] r_tmo;
  logic             r_err;

  // Held at zero outside WAIT so every WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || r_state != ST_WAIT) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES));
  assign o_err     = r_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit    = 1'b0;
  assign o_err        = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_clr      = 1'b0;
    w_add      = 1'b0;
    w_tmo_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nx = ST_REQ;
          w_k_nx     = 2'd0;
          w_clr      = 1'b1;
        end
      end
      ST_REQ:   w_state_nx = ST_WAIT;
      ST_WAIT: begin
        if (mm.mm_valid) begin
          w_add      = 1'b1;
          w_state_nx = ST_ACK;
        end else if (w_tmo_hit) begin
          w_tmo_err  = 1'b1;
          w_state_nx = ST_DONE;
        end
      end
      ST_ACK:   w_state_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (!mm.mm_valid) begin
          if (r_k == 2'd2) begin
            w_state_nx = ST_DONE;
          end else begin
            w_k_nx     = r_k + 2'd1;
            w_state_nx = ST_REQ;
          end
        end
      end
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // On the IDLE->REQ edge the operands are not latched yet, so select from the inputs.
  always_comb begin
    w_a_src = (r_state == ST_IDLE) ? i_a_mat : r_a;
    w_b_src = (r_state == ST_IDLE) ? i_b_mat : r_b;
    w_mm_a  = '0;
    w_mm_b  = '0;
    for (int i = 0; i < DIM; i++) begin
      w_mm_a[i*W +: W] = w_a_src[elem_idx(i, int'(w_k_nx))*W +: W];
      w_mm_b[i*W +: W] = w_b_src[elem_idx(int'(w_k_nx), i)*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_k      <= 2'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_mm_a   <= '0;
      r_mm_b   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b0;
      r_accept <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_k      <= w_k_nx;
      r_busy   <= (w_state_nx != ST_IDLE);
      r_done   <= (w_state_nx == ST_DONE);
      r_ready  <= (w_state_nx == ST_REQ);
      r_accept <= (w_state_nx == ST_ACK);
      if (w_clr) begin
        r_a <= i_a_mat;
        r_b <= i_b_mat;
      end
      if (w_state_nx == ST_REQ) begin
        r_mm_a <= w_mm_a;
        r_mm_b <= w_mm_b;
      end
      if (w_state_nx == ST_DONE) begin
        r_c <= w_acc;
      end
    end
  end

`ifdef MM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo_err;
    end
  end
`endif

  matmul3_acc_bank #(.W(W)) u_acc_bank (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_add_en (w_add),
    .i_mm_c   (mm.mm_c),
    .o_acc    (w_acc)
  );

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_c_mat      = r_c;
  assign mm.mm_ready  = r_ready;
  assign mm.mm_accept = r_accept;
  assign mm.mm_a      = r_mm_a;
  assign mm.mm_b      = r_mm_b;

endmodule

// File: doc/matmul3_outer_driver.md
Name: matmul3_outer_driver

Overview:
- Initiator side of the outer-product matmult handshake (ready/accept/valid).
- Computes a full 3x3 signed product C = A*B as the sum of three outer products. Pass k issues column k of A and row k of B to the outer-product unit, then accumulates the returned 3x3 partial result.
- Sits between the host/control layer, which loads A and B and pulses start, and one outer-product unit instance.

Parameters:
- W, 64, element width in bits (signed two's complement).
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT; used only with MM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle request to begin; sampled only in IDLE
- a_mat  in  9*W  A row-major; element [i][j] at bits (3*i+j)*W +: W
- b_mat  in  9*W  B row-major; same packing
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when c_mat is final
- err  out  1  one-cycle pulse alongside done on timeout; constant 0 without MM_TIMEOUT_EN
- c_mat  out  9*W  result row-major; held until next accepted start
- mm_ready  out  1  request to the outer-product unit
- mm_accept  out  1  result acknowledge to the outer-product unit
- mm_valid  in  1  result valid from the outer-product unit
- mm_a  out  3*W  column k of A; element i at i*W
- mm_b  out  3*W  row k of B; element j at j*W
- mm_c  in  9*W  outer product; element [i][j] at (3*i+j)*W

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. All outputs 0, c_mat 0, state IDLE, k=0, latched A/B 0.
- rst mid-operation aborts immediately with no done. The outer-product unit shares rst, so both ends restart in idle.
- States: IDLE, REQ, WAIT, ACK, DRAIN, DONE. All outputs are registered.
- IDLE: when start=1, latch a_mat/b_mat, clear all nine accumulators, set k=0, go to REQ. start in any other state is ignored.
- REQ (one cycle): mm_ready=1; mm_a = {A[2][k],A[1][k],A[0][k]}; mm_b = {B[k][2],B[k][1],B[k][0]}. Go to WAIT.
- mm_a/mm_b stay stable from REQ through DRAIN. mm_ready is 0 outside REQ.
- WAIT: mm_ready=0. On mm_valid=1: acc[i][j] += mm_c[i][j], then go to ACK.
- Accumulation is W-bit modular: overflow wraps, with no saturation and no flag.
- ACK (one cycle): mm_accept=1. Go to DRAIN. mm_accept is 0 in every other state.
- DRAIN: wait until mm_valid=0.
  - The unit holds valid high for one cycle after leaving fin, so DRAIN always lasts at least 2 cycles.
  - mm_valid is never sampled as new data in DRAIN.
  - On exit: if k==2 go to DONE, else k++ and go to REQ.
- DONE (one cycle): c_mat <= acc, done=1, go to IDLE. c_mat changes only here.
- Nominal timing with a compliant unit (capture on ready, one compute cycle, registered valid): 7 cycles per pass.
  - start is sampled at cycle 0.
  - REQ occurs at cycles 1, 8 and 15.
  - done asserts at cycle 22.
- If mm_valid stays high longer in DRAIN, the block waits. If mm_valid rises late in WAIT, the block waits indefinitely (unless MM_TIMEOUT_EN).

Optional Feature:
- Macro MM_TIMEOUT_EN.
- Defined: an 8+ bit counter clears on WAIT entry and increments every WAIT cycle. When it reaches TIMEOUT_CYCLES with mm_valid still 0:
  - go to DONE;
  - c_mat <= partial acc;
  - done=1 and err=1 in the same cycle;
  - no accept is issued.
- Not defined: no counter, err tied 0, WAIT is unbounded.

Decomposition:
- Shared package matmul_pkg: DIM=3, W=64, state enum (IDLE, REQ, WAIT, ACK, DRAIN, DONE), element-index helper (3*i+j).
- One natural sub-module, matmul3_acc_bank: nine W-bit accumulators with clr and add_en inputs, taking mm_c and exposing acc.

Test Plan:
- Identity: A=I, B=[1..9] row-major, start -> done at cycle 22 with c_mat=[1..9]; mm_ready high exactly 3 cycles; mm_accept high exactly 3 cycles.
- Signed values: A=[[1,-2,3],[0,4,-1],[2,2,2]], B=[[5,0,-1],[1,1,1],[-3,2,0]] -> c_mat=[[-6,4,-3],[7,2,4],[6,6,0]].
- Wrap: A[0][0]=B[0][0]=2^62 with others 0 -> c_mat[0][0]=0; A[0][0]=2^62-1, B[0][0]=2 -> 2^63-2.
- Slow unit: model delays valid 10 cycles per pass and holds valid 3 cycles after accept -> correct c_mat; no REQ while mm_valid=1; total latency 22+30+6=58 cycles.
- start during busy plus mid-pass rst: start asserted in WAIT is ignored. rst asserted in pass 1 -> busy=0, c_mat=0, no done; a following start completes normally.
- MM_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never raises valid -> done=1 and err=1 at cycle 19, c_mat=0, mm_accept never asserted.
